pwm_speed_ctrl: RTL

//  Consumer end of the debounced button path: takes one-cycle button pulses (up/down/stop)
//  and turns them into a speed level and a glitch-free, soft-ramped PWM drive for the motor.

---
 rtl/pwm_speed_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/pwm_speed_ctrl.sv
// Button-driven speed level with a soft-ramped, period-synchronous PWM motor drive.
// Duty moves toward the level's target by at most RAMP_STEP per period; stop forces duty to zero at once.
module pwm_speed_ctrl #(
   parameter int PERIOD    = 100_000,
   parameter int LEVELS    = 4,
   parameter int RAMP_STEP = 1_000
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_btn_up,
   input  logic       i_btn_down,
   input  logic       i_btn_stop,
   output logic       o_pwm,
   output logic [2:0] o_level,
   output logic       o_busy,
   output logic       o_period_tick
);

   localparam logic [31:0] LP_LAST      = 32'(PERIOD - 1);
   localparam logic [31:0] LP_PRE_LAST  = 32'(PERIOD - 2);
   localparam logic [31:0] LP_STEP      = 32'(RAMP_STEP);
   localparam logic [2:0]  LP_MAX_LEVEL = 3'(LEVELS);

   typedef enum logic [1:0] {ST_IDLE, ST_RAMP, ST_RUN} state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic [31:0] r_cnt;
   logic [31:0] r_duty;
   logic [2:0]  r_level;
   logic        r_pwm;
   logic        r_tick;

   logic [31:0] w_duty_next;
   logic [31:0] w_duty_step;
   logic [31:0] w_target;
   logic [31:0] w_target_next;
   logic [2:0]  w_level_next;
   logic [31:0] w_target_tab [0:7];

   // Constant level -> target table; entries above LEVELS are unreachable.
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_target
         if (gi <= LEVELS) begin : g_valid
            assign w_target_tab[gi] = 32'((64'(gi) * 64'(PERIOD)) / 64'(LEVELS));
         end else begin : g_unused
            assign w_target_tab[gi] = 32'(PERIOD);
         end
      end
   endgenerate

   always_comb begin
      w_level_next = r_level;
      if (i_btn_stop) begin
         w_level_next = 3'd0;
      end else if (i_btn_up && i_btn_down) begin
         w_level_next = r_level;
      end else if (i_btn_up) begin
         if (r_level < LP_MAX_LEVEL) w_level_next = r_level + 3'd1;
      end else if (i_btn_down) begin
         if (r_level != 3'd0) w_level_next = r_level - 3'd1;
      end
   end

   assign w_target      = w_target_tab[r_level];
   assign w_target_next = w_target_tab[w_level_next];

   // Compare distances rather than sums so the step can never wrap past the target.
   always_comb begin
      w_duty_step = r_duty;
      if (r_duty < w_target) begin
         if (w_target - r_duty > LP_STEP) w_duty_step = r_duty + LP_STEP;
         else                             w_duty_step = w_target;
      end else if (r_duty > w_target) begin
         if (r_duty - w_target > LP_STEP) w_duty_step = r_duty - LP_STEP;
         else                             w_duty_step = w_target;
      end
   end

   always_comb begin
      if (i_btn_stop)             w_duty_next = 32'd0;
      else if (r_cnt == LP_LAST)  w_duty_next = w_duty_step;
      else                        w_duty_next = r_duty;
   end

   always_comb begin
      if (w_duty_next == 32'd0 && w_target_next == 32'd0) w_state_next = ST_IDLE;
      else if (w_duty_next != w_target_next)               w_state_next = ST_RAMP;
      else                                                 w_state_next = ST_RUN;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_cnt   <= 32'd0;
         r_duty  <= 32'd0;
         r_level <= 3'd0;
         r_state <= ST_IDLE;
         r_pwm   <= 1'b0;
         r_tick  <= 1'b0;
      end else begin
         r_cnt   <= (r_cnt == LP_LAST) ? 32'd0 : r_cnt + 32'd1;
         r_tick  <= (r_cnt == LP_PRE_LAST);
         r_duty  <= w_duty_next;
         r_level <= w_level_next;
         r_state <= w_state_next;
         r_pwm   <= i_btn_stop ? 1'b0 : (r_cnt < r_duty);
      end
   end

   assign o_pwm         = r_pwm;
   assign o_level       = r_level;
   assign o_busy        = (r_state == ST_RAMP);
   assign o_period_tick = r_tick;

endmodule
